skeeball_game_ctrl: RTL and testbench
=====================================

Name: skeeball_game_ctrl

Overview:
Game controller that sits directly upstream of the skeeball ball counter (9-bit thermometer, decrements on each rising edge of its clock input while its game input is high, reloads 9 balls while game is low). Debounces the hole sensors, awards points per ball, and generates the counter's game level and one-cycle ball clock. Reads the counter's thermometer back to detect game over. Accumulates the game score for the display stage.

Parameters:
DEBOUNCE, 16, cycles a sensor condition must hold stable before it is accepted (range 2..255)
SCORE_W, 10, score width; 9 balls x 100 max = 900 fits

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  start button, level; raw, debounced internally
hole  in  7  hole sensors, active-high; [0]=gutter 0 pts, [1..6]=10,20,30,40,50,100 pts
balls_in  in  9  thermometer from ball counter (9'h1FF=9 balls ... 9'h000=0)
game  out  1  level to ball counter; high while a game is in progress
ball_clk  out  1  registered one-cycle pulse; drives the ball counter clock
score  out  SCORE_W  accumulated score, binary
game_over  out  1  high from end of game until next start
ball_scored  out  1  one-cycle pulse when a ball is accepted

Behaviour:
- Reset: state IDLE; game=0, ball_clk=0, score=0, game_over=0, ball_scored=0; debounce counters cleared. Reset mid-game aborts the game with no ball_clk pulse.
- Start debounce: start must be high for DEBOUNCE consecutive cycles, then one accept event. Start must go low for DEBOUNCE cycles before it can fire again. Start is ignored in LOAD, WAIT_LOAD, PLAY, SCORE, and REARM.
- States:
  - IDLE: game=0. Accepted start -> LOAD; score cleared to 0 on the same edge.
  - LOAD: game=0, ball_clk=1 for exactly one cycle. This makes the counter load 9 balls. -> WAIT_LOAD.
  - WAIT_LOAD: game=0. When balls_in==9'h1FF -> PLAY with game=1. After 8 cycles without a match -> LOAD again (retry).
  - PLAY: game=1. Hole debounce: OR of hole bits high for DEBOUNCE consecutive cycles -> SCORE. Any all-low cycle restarts the count.
  - SCORE (1 cycle): score += points of the highest-numbered hole bit high in this cycle. Gutter only adds 0. ball_clk=1 and ball_scored=1 for this single cycle. -> REARM.
  - REARM: game=1. Wait until hole==0 for DEBOUNCE consecutive cycles. Then: balls_in==9'h000 -> OVER; otherwise -> PLAY.
  - OVER: game=0, game_over=1, score held. Accepted start -> LOAD, with score cleared and game_over cleared.
- Simultaneous hole bits count as one ball; the highest value wins.
- A hole held high forever yields exactly one ball.
- Score add saturates at 2^SCORE_W-1 (unreachable with defaults; still required).
- Outputs are registered. ball_clk is never high in two consecutive cycles.
- Latency: debounced hole to ball_clk/ball_scored is 1 cycle. The counter update is visible on balls_in by the following cycle, well before REARM exits.
- balls_in values that are not valid thermometer codes in REARM are treated as non-zero (game continues).

Decomposition:
- Shared package skeeball_pkg: state encoding (IDLE, LOAD, WAIT_LOAD, PLAY, SCORE, REARM, OVER), hole point constants (0,10,20,30,40,50,100), BALLS_FULL=9'h1FF, BALLS_EMPTY=9'h000.
- One sub-module: skeeball_debounce. Parameter DEBOUNCE; inputs clk, reset, raw; outputs stable level and rise pulse. Instantiated for start and for the hole-OR.
- The REARM all-low wait uses its inverted stable output.

Test Plan:
- Reset during PLAY (score=60) -> next cycle game=0, score=0, state IDLE, no ball_clk pulse.
- Start held 16 cycles from IDLE, model counter attached -> exactly one ball_clk pulse with game=0, balls_in becomes 9'h1FF, then game=1.
- Hole[6] pulse 10 cycles (< DEBOUNCE) -> no score change; then hole[6] high 16 cycles -> score=100, one ball_clk, balls_in 9'h0FF.
- hole[2] and hole[5] high together 16 cycles -> score += 50, single ball_clk pulse; holding them 200 cycles gives no second ball.
- Nine balls: hole[1],hole[0],hole[6] x2,hole[3] x5 -> after ninth REARM game=0, game_over=1, score=360, balls_in 9'h000.
- In OVER, start pressed -> score clears to 0, game_over=0, new LOAD pulse, balls_in returns to 9'h1FF.

Source files
------------

// File: rtl/skeeball_pkg.sv
// skeeball_pkg: shared state encoding, hole point values and ball-counter codes.
package skeeball_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_LOAD,
        S_PLAY,
        S_SCORE,
        S_REARM,
        S_OVER
    } state_t;

    localparam int CNT_W = 8;
    localparam int WAIT_LOAD_CYCLES = 8;

    localparam logic [6:0] PTS_GUTTER = 7'd0;
    localparam logic [6:0] PTS_10     = 7'd10;
    localparam logic [6:0] PTS_20     = 7'd20;
    localparam logic [6:0] PTS_30     = 7'd30;
    localparam logic [6:0] PTS_40     = 7'd40;
    localparam logic [6:0] PTS_50     = 7'd50;
    localparam logic [6:0] PTS_100    = 7'd100;

    localparam logic [8:0] BALLS_FULL  = 9'h1FF;
    localparam logic [8:0] BALLS_EMPTY = 9'h000;

    // Highest-numbered hole wins when several sensors fire together.
    function automatic logic [6:0] hole_points(input logic [6:0] h);
        return h[6] ? PTS_100 :
               h[5] ? PTS_50  :
               h[4] ? PTS_40  :
               h[3] ? PTS_30  :
               h[2] ? PTS_20  :
               h[1] ? PTS_10  : PTS_GUTTER;
    endfunction

endpackage

// File: rtl/skeeball_debounce.sv
// skeeball_debounce: accepts a level change only after it holds for DEBOUNCE cycles.
module skeeball_debounce
    import skeeball_pkg::*;
#(
    parameter int DEBOUNCE = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic rise
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             rise_q, rise_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (raw != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE - 1)) stable_d = raw;
            else cnt_d = cnt_q + 1'b1;
        end
        rise_d = stable_d & ~stable_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
        end
    end

    assign stable = stable_q;
    assign rise   = rise_q;

endmodule

// File: rtl/skeeball_game_ctrl.sv
// skeeball_game_ctrl: debounces start/holes, drives the ball counter and keeps score.
module skeeball_game_ctrl
    import skeeball_pkg::*;
#(
    parameter int DEBOUNCE = 16,
    parameter int SCORE_W  = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [6:0]         hole,
    input  logic [8:0]         balls_in,
    output logic               game,
    output logic               ball_clk,
    output logic [SCORE_W-1:0] score,
    output logic               game_over,
    output logic               ball_scored
);

    state_t             state_q, state_d;
    logic [2:0]         wait_q, wait_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W:0]   sum;
    logic               game_q, game_d;
    logic               ball_clk_q, ball_clk_d;
    logic               game_over_q, game_over_d;
    logic               ball_scored_q, ball_scored_d;
    logic               start_stable, start_rise;
    logic               hole_stable, hole_rise;
    logic               unused;

    skeeball_debounce #(.DEBOUNCE(DEBOUNCE)) u_start_db (
        .clk    (clk),
        .reset  (reset),
        .raw    (start),
        .stable (start_stable),
        .rise   (start_rise)
    );

    skeeball_debounce #(.DEBOUNCE(DEBOUNCE)) u_hole_db (
        .clk    (clk),
        .reset  (reset),
        .raw    (|hole),
        .stable (hole_stable),
        .rise   (hole_rise)
    );

    assign unused = start_stable ^ hole_rise;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        score_d = score_q;
        sum     = {1'b0, score_q} + (SCORE_W + 1)'(hole_points(hole));
        case (state_q)
            S_IDLE, S_OVER: if (start_rise) begin
                state_d = S_LOAD;
                score_d = '0;
            end
            S_LOAD: begin
                state_d = S_WAIT_LOAD;
                wait_d  = '0;
            end
            S_WAIT_LOAD: begin
                if (balls_in == BALLS_FULL) state_d = S_PLAY;
                else if (wait_q == 3'(WAIT_LOAD_CYCLES - 1)) state_d = S_LOAD;
                else wait_d = wait_q + 1'b1;
            end
            S_PLAY: if (hole_stable) state_d = S_SCORE;
            S_SCORE: begin
                state_d = S_REARM;
                score_d = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
            end
            // Malformed thermometer codes count as balls remaining.
            S_REARM: if (!hole_stable) state_d = (balls_in == BALLS_EMPTY) ? S_OVER : S_PLAY;
            default: state_d = S_IDLE;
        endcase
        game_d        = state_d inside {S_PLAY, S_SCORE, S_REARM};
        ball_clk_d    = state_d inside {S_LOAD, S_SCORE};
        ball_scored_d = state_d == S_SCORE;
        game_over_d   = state_d == S_OVER;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            wait_q        <= '0;
            score_q       <= '0;
            game_q        <= 1'b0;
            ball_clk_q    <= 1'b0;
            game_over_q   <= 1'b0;
            ball_scored_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            score_q       <= score_d;
            game_q        <= game_d;
            ball_clk_q    <= ball_clk_d;
            game_over_q   <= game_over_d;
            ball_scored_q <= ball_scored_d;
        end
    end

    assign game        = game_q;
    assign ball_clk    = ball_clk_q;
    assign score       = score_q;
    assign game_over   = game_over_q;
    assign ball_scored = ball_scored_q;

    a_bclk_single: assert property (@(posedge clk) disable iff (reset) ball_clk_q |=> !ball_clk_q);
    a_game_excl:   assert property (@(posedge clk) disable iff (reset) !(game_q && game_over_q));

endmodule

// File: tb/tb_skeeball_game_ctrl.sv
// tb_skeeball_game_ctrl: vector table plus score scoreboard against a ball-counter model.
module tb_skeeball_game_ctrl;

    typedef struct {
        logic [6:0] hole;
        int         hold;
        int         ball;
        logic [9:0] score;
        logic [8:0] balls;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [6:0] hole = '0;
    logic [8:0] balls_in;
    logic       game, ball_clk, game_over, ball_scored;
    logic [9:0] score;

    logic [8:0] balls_m = 9'h000;
    logic       model_en = 1'b1;
    int         n_cmp = 0, n_bad = 0, n_bclk = 0;
    logic       prev_bclk = 1'b0, sc_pend = 1'b0;
    logic [9:0] exp_q[$];
    vec_t       v[$];

    always #5 clk = ~clk;

    skeeball_game_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .hole        (hole),
        .balls_in    (balls_in),
        .game        (game),
        .ball_clk    (ball_clk),
        .score       (score),
        .game_over   (game_over),
        .ball_scored (ball_scored)
    );

    // Ball counter: reload while game is low, shift one ball out while high.
    always @(posedge clk) if (ball_clk) balls_m <= game ? (balls_m >> 1) : 9'h1FF;
    assign balls_in = model_en ? balls_m : 9'h000;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (ball_clk) begin
            n_bclk++;
            chk("bclk_not_back_to_back", 32'(prev_bclk), 0);
        end
        prev_bclk = ball_clk;
    end

    always @(negedge clk) begin
        if (sc_pend) begin
            if (exp_q.size() == 0) chk("unexpected_ball", 1, 0);
            else chk("sb_score", 32'(score), 32'(exp_q.pop_front()));
        end
        sc_pend = ball_scored;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        start = 1'b0;
        hole  = '0;
        tick(3);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic start_game(input string nm);
        int b0, t;
        b0 = n_bclk;
        t  = 0;
        start = 1'b1;
        while (!game && t < 60) begin
            tick(1);
            t++;
        end
        chk({nm, "_started"}, 32'(game), 1);
        chk({nm, "_load_pulses"}, n_bclk - b0, 1);
        chk({nm, "_balls_full"}, 32'(balls_in), 32'h1FF);
        chk({nm, "_score_clear"}, 32'(score), 0);
        chk({nm, "_over_clear"}, 32'(game_over), 0);
        start = 1'b0;
    endtask

    task automatic run_vec(input int i);
        int b0;
        b0 = n_bclk;
        if (v[i].ball != 0) exp_q.push_back(v[i].score);
        hole = v[i].hole;
        tick(v[i].hold);
        hole = '0;
        tick(22);
        chk($sformatf("v%0d_pulses", i), n_bclk - b0, v[i].ball);
        chk($sformatf("v%0d_balls", i), 32'(balls_in), 32'(v[i].balls));
        chk($sformatf("v%0d_score", i), 32'(score), 32'(v[i].score));
    endtask

    function automatic vec_t mk(logic [6:0] h, int hold, int ball, logic [9:0] s, logic [8:0] b);
        vec_t x;
        x.hole = h; x.hold = hold; x.ball = ball; x.score = s; x.balls = b;
        return x;
    endfunction

    initial begin
        int b0, t, cnt;
        v.push_back(mk(7'h02, 20, 1, 10, 9'h0FF));
        v.push_back(mk(7'h20, 20, 1, 60, 9'h07F));
        v.push_back(mk(7'h40, 10, 0, 0, 9'h1FF));
        v.push_back(mk(7'h40, 15, 0, 0, 9'h1FF));
        v.push_back(mk(7'h40, 20, 1, 100, 9'h0FF));
        v.push_back(mk(7'h24, 200, 1, 150, 9'h07F));
        v.push_back(mk(7'h02, 20, 1, 10, 9'h0FF));
        v.push_back(mk(7'h01, 20, 1, 10, 9'h07F));
        v.push_back(mk(7'h40, 20, 1, 110, 9'h03F));
        v.push_back(mk(7'h40, 20, 1, 210, 9'h01F));
        v.push_back(mk(7'h08, 20, 1, 240, 9'h00F));
        v.push_back(mk(7'h08, 20, 1, 270, 9'h007));
        v.push_back(mk(7'h08, 20, 1, 300, 9'h003));
        v.push_back(mk(7'h08, 20, 1, 330, 9'h001));
        v.push_back(mk(7'h08, 20, 1, 360, 9'h000));

        do_reset();
        chk("rst_game", 32'(game), 0);
        chk("rst_ball_clk", 32'(ball_clk), 0);
        chk("rst_score", 32'(score), 0);
        chk("rst_game_over", 32'(game_over), 0);
        chk("rst_ball_scored", 32'(ball_scored), 0);

        // Counter never reports full: LOAD must retry every 9 cycles.
        model_en = 1'b0;
        start = 1'b1;
        t = 0;
        while (!ball_clk && t < 60) begin
            tick(1);
            t++;
        end
        cnt = 0;
        for (int k = 0; k < 23; k++) begin
            if (ball_clk) cnt++;
            tick(1);
        end
        chk("retry_pulses", cnt, 3);
        chk("retry_game_low", 32'(game), 0);
        model_en = 1'b1;
        start = 1'b0;
        t = 0;
        while (!game && t < 30) begin
            tick(1);
            t++;
        end
        chk("retry_started", 32'(game), 1);
        chk("retry_score", 32'(score), 0);
        for (int i = 0; i < 2; i++) run_vec(i);

        reset = 1'b1;
        b0 = n_bclk;
        tick(1);
        chk("midrst_game", 32'(game), 0);
        chk("midrst_score", 32'(score), 0);
        chk("midrst_ball_clk", 32'(ball_clk), 0);
        tick(2);
        reset = 1'b0;
        tick(20);
        chk("midrst_no_pulse", n_bclk - b0, 0);
        chk("midrst_idle", 32'(game), 0);

        start_game("g1");
        for (int i = 2; i < 6; i++) run_vec(i);
        do_reset();

        start_game("g2");
        for (int i = 6; i < 15; i++) run_vec(i);
        chk("over_game", 32'(game), 0);
        chk("over_flag", 32'(game_over), 1);
        tick(30);
        chk("over_score_held", 32'(score), 360);

        start_game("g3");
        chk("sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
